// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package rr_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int N_DEF = 4;
    localparam int W_DEF = 4;

    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import rr_mux_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic [N-1:0] rot;

    always_comb begin
        // Rotating the doubled vector puts req[ptr] at bit 0.
        rot    = N'({req, req} >> ptr);
        any    = |req;
        gnt_id = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_id = ptr + IW'(k);
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with packet lock driving a registered N:1 mux output stage.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*W-1:0]       in_data,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic                 out_last,
    output logic [$clog2(N)-1:0] out_id,
    input  logic                 out_ready
);

    // state  | meaning
    // IDLE   | round-robin pick from ptr; single-beat packets advance ptr
    // LOCKED | only lock_id may transfer until its last beat

    localparam int IW = $clog2(N);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] lock_id_q, lock_id_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic [IW-1:0] out_id_q, out_id_d;

    logic [IW-1:0] pick_id;
    logic          pick_any;
    logic [IW-1:0] grant;
    logic [W-1:0]  sel_data;
    logic          sel_last;
    logic          adv;
    logic          xfer;

    rr_pick #(.N(N)) u_pick (
        .req    (in_valid),
        .ptr    (ptr_q),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    always_comb begin
        grant    = (state_q == LOCKED) ? lock_id_q : pick_id;
        adv      = !out_valid_q || out_ready;
        sel_data = '0;
        sel_last = 1'b0;
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == IW'(i)) begin
                sel_data    = in_data[i*W +: W];
                sel_last    = in_last[i];
                // rst_n gating keeps the handshake closed while the flops are held.
                in_ready[i] = rst_n & adv & in_valid[i] & (pick_any | (state_q == LOCKED));
            end
        end
        xfer = |in_ready;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_id_d   = lock_id_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_id_d    = out_id_q;

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_id_d    = grant;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (sel_last) begin
                        ptr_d = IW'(wrap_add(int'(grant), 1, N));
                    end else begin
                        state_d   = LOCKED;
                        lock_id_d = grant;
                    end
                end
            end
            LOCKED: begin
                if (xfer && sel_last) begin
                    state_d = IDLE;
                    ptr_d   = IW'(wrap_add(int'(lock_id_q), 1, N));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            lock_id_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_id_q   <= lock_id_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: scoreboard monitor plus per-scenario tasks.
module tb_rr_mux_arbiter;
    import rr_mux_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic        out_last;
    logic [1:0]  out_id;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] id;
        logic [3:0] data;
        logic       last;
    } beat_t;

    beat_t sb[$];
    int    served[$];

    arb_state_t m_state = IDLE;
    logic [1:0] m_ptr   = 2'd0;
    logic [1:0] m_lock  = 2'd0;
    logic       m_ov    = 1'b0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.N(4), .W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model runs at the falling edge, where inputs and DUT state are settled.
    task automatic monitor();
        beat_t      b;
        logic [3:0] exp_rdy;
        logic       adv;
        int         g;
        int         idx;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_state = IDLE;
                m_ptr   = 2'd0;
                m_lock  = 2'd0;
                m_ov    = 1'b0;
                sb.delete();
                checks++;
                if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_hold: in_ready=%b out_valid=%b required 0000/0", in_ready, out_valid);
                end
            end else begin
                checks++;
                if (out_valid !== m_ov) begin
                    errors++;
                    $display("FAIL out_valid: got %b expected %b", out_valid, m_ov);
                end
                if (m_ov && out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_underflow: output beat id=%0d with empty scoreboard", out_id);
                    end else begin
                        b = sb.pop_front();
                        if (out_id !== b.id || out_data !== b.data || out_last !== b.last) begin
                            errors++;
                            $display("FAIL out_beat: got id=%0d data=%h last=%b expected id=%0d data=%h last=%b",
                                     out_id, out_data, out_last, b.id, b.data, b.last);
                        end
                    end
                    served.push_back(int'(out_id));
                end
                adv = !m_ov || out_ready;
                g   = -1;
                if (m_state == LOCKED) begin
                    g = int'(m_lock);
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        idx = (int'(m_ptr) + k) % 4;
                        if (g < 0 && in_valid[idx]) g = idx;
                    end
                end
                exp_rdy = 4'b0000;
                if (g >= 0 && adv && in_valid[g]) exp_rdy[g] = 1'b1;
                checks++;
                if (in_ready !== exp_rdy) begin
                    errors++;
                    $display("FAIL in_ready: got %b expected %b", in_ready, exp_rdy);
                end
                if (exp_rdy != 4'b0000) begin
                    b.id   = 2'(g);
                    b.data = in_data[g*4 +: 4];
                    b.last = in_last[g];
                    sb.push_back(b);
                    m_ov = 1'b1;
                    if (m_state == IDLE) begin
                        if (in_last[g]) begin
                            m_ptr = 2'((g + 1) % 4);
                        end else begin
                            m_state = LOCKED;
                            m_lock  = 2'(g);
                        end
                    end else if (in_last[g]) begin
                        m_state = IDLE;
                        m_ptr   = 2'((g + 1) % 4);
                    end
                end else if (out_ready) begin
                    m_ov = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        int e[5] = '{0, 1, 2, 3, 0};
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        in_data   = 16'h4321;
        out_ready = 1'b1;
        repeat (2) step();
        @(negedge clk);
        checks++;
        if (in_ready !== 4'b0000 || out_valid !== 1'b0 || out_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_id=%0d required 0000/0/0",
                     in_ready, out_valid, out_id);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        served.delete();
        for (int c = 0; c < 5; c++) begin
            in_data = 16'($urandom);
            step();
        end
        in_valid = 4'b0000;
        repeat (3) step();
        checks++;
        if (served.size() != 5) begin
            errors++;
            $display("FAIL rr_count: got %0d beats expected 5", served.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ((served.size() > i ? served[i] : -1) != e[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", i, (served.size() > i ? served[i] : -1), e[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int e[4] = '{1, 2, 3, 0};
        served.delete();
        in_last  = 4'b1111;
        in_valid = 4'b0110;
        in_data  = 16'($urandom);
        step();
        in_data  = 16'($urandom);
        step();
        in_valid = 4'b1001;
        in_data  = 16'($urandom);
        step();
        in_data  = 16'($urandom);
        step();
        in_valid = 4'b0000;
        repeat (2) step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ((served.size() > i ? served[i] : -1) != e[i]) begin
                errors++;
                $display("FAIL wrap_order[%0d]: got %0d expected %0d", i, (served.size() > i ? served[i] : -1), e[i]);
            end
        end
    endtask

    task automatic test_lock();
        int e[5] = '{1, 1, 1, 2, 0};
        served.delete();
        in_valid = 4'b0111;
        in_last  = 4'b1101;
        in_data  = 16'($urandom);
        step();
        in_data  = 16'($urandom);
        step();
        in_last  = 4'b1111;
        in_data  = 16'($urandom);
        step();
        in_valid = 4'b0101;
        in_data  = 16'($urandom);
        step();
        in_data  = 16'($urandom);
        step();
        in_valid = 4'b0000;
        repeat (2) step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ((served.size() > i ? served[i] : -1) != e[i]) begin
                errors++;
                $display("FAIL lock_order[%0d]: got %0d expected %0d", i, (served.size() > i ? served[i] : -1), e[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] x;
        served.delete();
        out_ready = 1'b1;
        in_valid  = 4'b0001;
        in_last   = 4'b1111;
        in_data   = 16'($urandom);
        x         = in_data[3:0];
        step();
        out_ready     = 1'b0;
        in_data[3:0]  = ~x;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== x || out_id !== 2'd0 || in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b data=%h id=%0d rdy=%b expected 1/%h/0/0000",
                         c, out_valid, out_data, out_id, in_ready, x);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        step();
        in_valid = 4'b0000;
        repeat (2) step();
        checks++;
        if (served.size() != 2) begin
            errors++;
            $display("FAIL stall_release: got %0d beats expected 2", served.size());
        end
    endtask

    task automatic test_locked_gap();
        int e[3] = '{2, 2, 0};
        served.delete();
        in_valid = 4'b0101;
        in_last  = 4'b1011;
        in_data  = 16'($urandom);
        step();
        in_valid = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL gap_block[%0d]: got in_ready=%b expected 0000", c, in_ready);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 4'b0101;
        in_last  = 4'b1111;
        in_data  = 16'($urandom);
        step();
        in_data  = 16'($urandom);
        step();
        in_valid = 4'b0000;
        repeat (2) step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ((served.size() > i ? served[i] : -1) != e[i]) begin
                errors++;
                $display("FAIL gap_order[%0d]: got %0d expected %0d", i, (served.size() > i ? served[i] : -1), e[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 4'b1000;
        in_last  = 4'b0000;
        in_data  = 16'($urandom);
        step();
        in_data  = 16'($urandom);
        step();
        rst_n    = 1'b0;
        in_valid = 4'b1111;
        in_last  = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_hold[%0d]: got rdy=%b v=%b expected 0000/0", c, in_ready, out_valid);
            end
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        served.delete();
        in_data = 16'($urandom);
        step();
        in_valid = 4'b0000;
        repeat (2) step();
        checks++;
        if (served.size() != 1 || served[0] != 0) begin
            errors++;
            $display("FAIL midrst_first: got %0d beats first=%0d expected 1 beat from 0",
                     served.size(), (served.size() > 0 ? served[0] : -1));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        in_last   = 4'b0000;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_wrap();
        test_lock();
        test_backpressure();
        test_locked_gap();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending beats expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Round-robin arbiter and sequencer for a shared 4:1 data mux. Up to N requesters present W-bit beats with valid/ready handshakes. The block picks one requester, steers the mux select and registers the chosen beat onto a single valid/ready output. Packet lock keeps a multi-beat packet from one requester contiguous.

Parameters:
N, 4, number of requesters; power of two, 2..8
W, 4, data width per beat

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  N  per-requester beat valid
in_data  in  N*W  per-requester beat data; requester i occupies bits [i*W +: W]
in_last  in  N  per-requester last-beat-of-packet flag
in_ready  out  N  per-requester accept; one-hot or zero
out_valid  out  1  registered output beat valid
out_data  out  W  registered output beat data
out_last  out  1  registered last flag
out_id  out  $clog2(N)  index of the requester that sourced the beat
out_ready  in  1  downstream accept

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, out_id=0, ptr=0, state=IDLE. All in_ready=0 while rst_n=0.
- Output register stage:
  - adv = !out_valid | out_ready.
  - Transfer on requester i when in_valid[i] & in_ready[i].
  - in_ready[i] = adv & (grant == i) & in_valid[i]. Combinational, at most one bit set.
- Latency: an input accepted in cycle t appears on out_* in cycle t+1.
- Back-to-back full throughput (1 beat/cycle) while out_ready=1.
- If out_valid & !out_ready: out_* hold stable and no input is accepted.
- out_valid drops to 0 after a downstream transfer with no new input accepted.
- Grant selection in IDLE: first i with in_valid[i] set, scanning ptr, ptr+1, ... mod N.
- Grant selection in LOCKED: grant = lock_id regardless of other requesters.
- States:
  - IDLE: on a transfer with in_last=1, stay IDLE and set ptr=(grant+1) mod N. On a transfer with in_last=0, go LOCKED, set lock_id=grant, ptr unchanged.
  - LOCKED: only lock_id may transfer. On a transfer with in_last=1, go IDLE and set ptr=(lock_id+1) mod N. A gap in in_valid[lock_id] stalls the output; other requesters stay blocked.
- ptr changes only on a packet-ending transfer. With no transfer, ptr and state hold.
- Simultaneous requests: the one nearest ptr (wrapping) wins. With all N valid and single-beat packets, grants go ptr, ptr+1, ... strictly in order.
- Width rules: ptr and lock_id are $clog2(N) bits. Wrap from N-1 to 0 is by natural overflow, since N is a power of two.
- Reset mid-packet: returns to IDLE with ptr=0. The partial packet is abandoned and no recovery state is kept.
- Inputs with in_valid=0 are don't-care. out_data updates only on transfer.

Decomposition:
- Shared package rr_mux_pkg:
  - state enum arb_state_t {IDLE, LOCKED}
  - default constants N_DEF=4, W_DEF=4
  - function for the wrapped index add
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[N], ptr.
  - Outputs: gnt_id, any.
  - Implementation: double-width rotate plus priority encode.
- Top-level contents: the registers, the FSM and the data select, which is an N:1 mux on gnt_id.

Test Plan:
1. Reset behaviour: assert rst_n=0 with in_valid=4'b1111 → in_ready=0, out_valid=0, out_id=0. Release, all valid, single-beat, out_ready=1 → out_id sequence 0,1,2,3,0 on consecutive cycles, out_data matching each source.
2. Pointer wrap: ptr at 3 after granting 2, in_valid=4'b1001 → requester 3 served, then requester 0; ptr ends at 1.
3. Packet lock: req1 sends 3 beats A,B,C (last on C) while req0 and req2 stay valid → out_id=1 for 3 consecutive beats, then req2, then req0.
4. Backpressure: out_ready=0 for 5 cycles with a beat held → out_data/out_id stable, in_ready=0. Raise out_ready → next beat on the following cycle with no loss or duplication.
5. Locked gap: req2 drops in_valid mid-packet for 2 cycles while req0 is valid → no grant to req0 until req2's last beat transfers.
6. Reset mid-packet: assert rst_n during LOCKED on req3 → state IDLE, ptr=0; after release with all valid, req0 is granted first.
